// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit
//   Program counter for the fetch stage. It supports increment, absolute jump,
//   signed relative branch, call/return through a small LIFO return stack,
//   and a RUN / HALT / FAULT state machine. All outputs come from registers.
//
// Ports
//   clk      : system clock; all state changes on the rising edge
//   reset    : synchronous active-high reset; overrides every other input
//   ld       : advance enable; PC actions happen only with ld=1 in RUN
//   jmp      : absolute jump to jmp_addr
//   jmp_addr : jump / call target
//   br       : relative branch by br_off
//   br_off   : two's-complement branch offset (OFF_W bits)
//   call     : push result+1, then go to jmp_addr
//   ret      : pop the return address into result
//   halt_req : enter HALT (beats any ld action in the same cycle)
//   resume   : leave HALT (ignored while halt_req is also high)
//   result   : current PC
//   sp       : number of occupied return-stack entries
//   halted   : high in HALT
//   fault    : high in FAULT (stack overflow or underflow; sticky until reset)
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int                 ADDR_W      = 4,
    parameter int                 OFF_W       = 4,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ld,
    input  logic                              jmp,
    input  logic [ADDR_W-1:0]                 jmp_addr,
    input  logic                              br,
    input  logic [OFF_W-1:0]                  br_off,
    input  logic                              call,
    input  logic                              ret,
    input  logic                              halt_req,
    input  logic                              resume,
    output logic [ADDR_W-1:0]                 result,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  sp,
    output logic                              halted,
    output logic                              fault
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [SP_W-1:0]     r_sp;
    logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];

    logic                w_act;
    logic                w_stack_empty;
    logic                w_stack_full;
    logic                w_push;
    logic [IDX_W-1:0]    w_push_idx;
    logic [IDX_W-1:0]    w_pop_idx;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_br_ext;

    // An action is taken only in RUN with ld high and no halt request.
    assign w_act         = (r_state == ST_RUN) && !halt_req && ld;
    assign w_stack_empty = (r_sp == '0);
    assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));

    // call only pushes when ret does not outrank it and the stack has room.
    assign w_push     = !reset && w_act && !ret && call && !w_stack_full;
    assign w_push_idx = IDX_W'(r_sp);
    assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));

    assign w_pc_inc = r_pc + ADDR_W'(1);
    // Size cast of a signed operand sign-extends; also covers OFF_W == ADDR_W.
    assign w_br_ext = ADDR_W'($signed(br_off));

    // Return stack storage: contents are don't-care after reset, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_ADDR;
            r_sp    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt_req) begin
                        r_state <= ST_HALT;
                    end else if (ld) begin
                        // Fixed priority: ret > call > jmp > br > increment.
                        if (ret) begin
                            if (w_stack_empty) begin
                                r_state <= ST_FAULT;
                            end else begin
                                r_pc <= r_stack[w_pop_idx];
                                r_sp <= r_sp - SP_W'(1);
                            end
                        end else if (call) begin
                            if (w_stack_full) begin
                                r_state <= ST_FAULT;
                            end else begin
                                r_pc <= jmp_addr;
                                r_sp <= r_sp + SP_W'(1);
                            end
                        end else if (jmp) begin
                            r_pc <= jmp_addr;
                        end else if (br) begin
                            r_pc <= r_pc + w_br_ext;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                ST_HALT: begin
                    // A fresh halt request wins over resume.
                    if (resume && !halt_req) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign result = r_pc;
    assign sp     = r_sp;
    assign halted = (r_state == ST_HALT);
    assign fault  = (r_state == ST_FAULT);

endmodule
